// File: rtl/dmac_burst_channel_ctrl_if.sv
// dmac_burst_channel_ctrl_if: AHB master and channel FIFO signals of one DMA channel
interface dmac_burst_channel_ctrl_if #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] haddr;
  logic [1:0] htrans;
  logic hwrite, hready, hresp, fifo_empty, fifo_push, fifo_pop;
  modport master (output haddr, htrans, hwrite, fifo_push, fifo_pop, input hready, hresp, fifo_empty);
  modport slave (input haddr, htrans, hwrite, fifo_push, fifo_pop, output hready, hresp, fifo_empty);
endinterface

// File: rtl/dmac_burst_channel_ctrl.sv
// dmac_burst_channel_ctrl: single-channel AHB DMA sequencer moving chunks read-burst into FIFO then write-burst out
module dmac_burst_channel_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W = 16,
  parameter int MAX_BURST = 16,
  parameter int BL_W = 5,
  parameter int BEAT_BYTES = 4
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic channel_en,
  input logic [ADDR_W-1:0] src_addr,
  input logic [ADDR_W-1:0] dst_addr,
  input logic [CNT_W-1:0] xfer_size,
  input logic [BL_W-1:0] burst_len,
  input logic src_inc,
  input logic dst_inc,
  input logic irq_clr,
  dmac_burst_channel_ctrl_if.master bus,
  output logic busy,
  output logic done_irq,
  output logic err_irq
);
  typedef enum logic [2:0] {IDLE, RD_BURST, RD_DRAIN, WR_BURST, WR_DRAIN, ERR} state_t;
  localparam logic [1:0] T_IDLE = 2'b00, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BEAT_BYTES);
  state_t state;
  logic [ADDR_W-1:0] src, dst, src_nxt, dst_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic [BL_W-1:0] bl, bl_in, chunk, acc_cnt, n;
  logic s_inc, d_inc, dph, acc, dcomp, err, rd, stall, last, go, done_set;
  function automatic logic [BL_W-1:0] min_chunk(input logic [CNT_W-1:0] r, input logic [BL_W-1:0] b);
    return r < CNT_W'(b) ? BL_W'(r) : b;
  endfunction
  always_comb begin
    acc = bus.htrans[1] & bus.hready;
    err = dph & bus.hresp;
    dcomp = dph & bus.hready & ~bus.hresp;
    rd = state == RD_BURST || state == RD_DRAIN;
    stall = bus.htrans[1] & ~bus.hready;
    n = acc_cnt + BL_W'(acc);
    last = n == chunk;
    // only the first beat of a chunk waits for the FIFO to have drained
    go = channel_en & (state == WR_BURST || n != '0 || bus.fifo_empty);
    src_nxt = src + (acc & rd & s_inc ? STEP : '0);
    dst_nxt = dst + (acc & ~rd & d_inc ? STEP : '0);
    bl_in = burst_len == '0 ? BL_W'(1) : burst_len > BL_W'(MAX_BURST) ? BL_W'(MAX_BURST) : burst_len;
    rem_nxt = rem - CNT_W'(chunk);
    done_set = (state == IDLE && start && xfer_size == '0) || (state == WR_DRAIN && dcomp && rem_nxt == '0);
  end
  assign bus.fifo_push = dcomp & rd;
  assign bus.fifo_pop = acc & ~rd & ~err;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      src <= '0;
      dst <= '0;
      rem <= '0;
      bl <= '0;
      chunk <= '0;
      acc_cnt <= '0;
      s_inc <= 1'b0;
      d_inc <= 1'b0;
      dph <= 1'b0;
      bus.haddr <= '0;
      bus.htrans <= T_IDLE;
      bus.hwrite <= 1'b0;
      done_irq <= 1'b0;
      err_irq <= 1'b0;
    end else begin
      src <= src_nxt;
      dst <= dst_nxt;
      dph <= acc | (dph & ~bus.hready);
      done_irq <= done_set | (done_irq & ~irq_clr);
      err_irq <= err | (err_irq & ~irq_clr);
      if (err) begin
        state <= ERR;
        bus.htrans <= T_IDLE;
        dph <= 1'b0;
      end else
        case (state)
          IDLE: if (start) begin
            src <= src_addr;
            dst <= dst_addr;
            s_inc <= src_inc;
            d_inc <= dst_inc;
            rem <= xfer_size;
            bl <= bl_in;
            chunk <= min_chunk(xfer_size, bl_in);
            acc_cnt <= '0;
            state <= xfer_size == '0 ? IDLE : RD_BURST;
          end
          RD_BURST, WR_BURST: if (!stall) begin
            acc_cnt <= n;
            if (last) begin
              bus.htrans <= T_IDLE;
              state <= state == RD_BURST ? RD_DRAIN : WR_DRAIN;
            end else if (go) begin
              bus.htrans <= bus.htrans[1] ? T_SEQ : T_NSEQ;
              bus.haddr <= rd ? src_nxt : dst_nxt;
              bus.hwrite <= state == WR_BURST;
            end else
              bus.htrans <= T_IDLE;
          end
          RD_DRAIN: if (dcomp) begin
            acc_cnt <= '0;
            state <= WR_BURST;
          end
          WR_DRAIN: if (dcomp) begin
            rem <= rem_nxt;
            acc_cnt <= '0;
            chunk <= min_chunk(rem_nxt, bl);
            state <= rem_nxt == '0 ? IDLE : RD_BURST;
          end
          ERR: if (irq_clr) state <= IDLE;
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_dmac_burst_channel_ctrl.sv
// tb_dmac_burst_channel_ctrl: directed vector table plus corner-case sequences for the DMA channel sequencer
module tb_dmac_burst_channel_ctrl;
  typedef struct {
    logic [15:0] xfer;
    logic [4:0] bl;
    logic [31:0] src;
    logic [31:0] dst;
    logic si;
    logic di;
    int ebl;
  } vec_t;
  logic clk = 0, rst = 1, start = 0, channel_en = 1, src_inc = 1, dst_inc = 1, irq_clr = 0;
  logic [31:0] src_addr = 0, dst_addr = 0;
  logic [15:0] xfer_size = 0;
  logic [4:0] burst_len = 0;
  logic busy, done_irq, err_irq;
  int n_cmp = 0, n_bad = 0, push_n = 0, pop_n = 0, fifo_cnt = 0;
  logic [31:0] rd_a[$], wr_a[$];
  logic [1:0] rd_t[$], wr_t[$];
  vec_t vecs[6];
  dmac_burst_channel_ctrl_if bus();
  dmac_burst_channel_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .channel_en(channel_en),
    .src_addr(src_addr), .dst_addr(dst_addr), .xfer_size(xfer_size), .burst_len(burst_len),
    .src_inc(src_inc), .dst_inc(dst_inc), .irq_clr(irq_clr), .bus(bus),
    .busy(busy), .done_irq(done_irq), .err_irq(err_irq)
  );
  always #5 clk = ~clk;
  assign bus.fifo_empty = fifo_cnt == 0;
  always @(negedge clk)
    if (rst) fifo_cnt = 0;
    else begin
      if (bus.fifo_push) begin push_n++; fifo_cnt++; end
      if (bus.fifo_pop) begin pop_n++; fifo_cnt--; end
      if (bus.htrans[1] && bus.hready) begin
        if (bus.hwrite) begin wr_a.push_back(bus.haddr); wr_t.push_back(bus.htrans); end
        else begin rd_a.push_back(bus.haddr); rd_t.push_back(bus.htrans); end
      end
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cfg(input logic [31:0] s, input logic [31:0] d, input logic [15:0] x, input logic [4:0] b, input logic si, input logic di);
    src_addr = s; dst_addr = d; xfer_size = x; burst_len = b; src_inc = si; dst_inc = di;
  endtask
  task automatic pulse_start;
    start = 1; tick; start = 0;
  endtask
  task automatic wait_done(input string nm);
    int t = 0;
    while (!done_irq && t < 3000) begin tick; t++; end
    chk({nm, "_done"}, done_irq, 1);
  endtask
  task automatic clear_irq(input string nm);
    irq_clr = 1; tick; irq_clr = 0;
    chk({nm, "_irq_clr"}, {done_irq, err_irq}, 0);
  endtask
  task automatic do_reset;
    rst = 1; tick; tick; rst = 0; tick;
  endtask
  task automatic run_vec(input vec_t v, input int idx);
    int rb = rd_a.size(), wb = wr_a.size(), pb = push_n, ob = pop_n, bad_a = 0, bad_t = 0;
    string nm = $sformatf("vec%0d", idx);
    logic [31:0] ea;
    logic [1:0] et;
    cfg(v.src, v.dst, v.xfer, v.bl, v.si, v.di);
    pulse_start;
    wait_done(nm);
    tick;
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_rd_beats"}, rd_a.size() - rb, 32'(v.xfer));
    chk({nm, "_wr_beats"}, wr_a.size() - wb, 32'(v.xfer));
    chk({nm, "_pushes"}, push_n - pb, 32'(v.xfer));
    chk({nm, "_pops"}, pop_n - ob, 32'(v.xfer));
    for (int i = 0; i < int'(v.xfer); i++) begin
      et = (i % v.ebl == 0) ? 2'b10 : 2'b11;
      ea = v.src + (v.si ? 32'(4 * i) : 32'd0);
      if (rb + i >= rd_a.size() || rd_a[rb + i] !== ea) bad_a++;
      if (rb + i >= rd_t.size() || rd_t[rb + i] !== et) bad_t++;
      ea = v.dst + (v.di ? 32'(4 * i) : 32'd0);
      if (wb + i >= wr_a.size() || wr_a[wb + i] !== ea) bad_a++;
      if (wb + i >= wr_t.size() || wr_t[wb + i] !== et) bad_t++;
    end
    chk({nm, "_addr_errs"}, bad_a, 0);
    chk({nm, "_trans_errs"}, bad_t, 0);
    clear_irq(nm);
  endtask
  initial begin
    int t, pb, ob, rb, wb, ns;
    bus.hready = 1;
    bus.hresp = 0;
    vecs[0] = '{16'd8, 5'd4, 32'h1000, 32'h2000, 1'b1, 1'b1, 4};
    vecs[1] = '{16'd5, 5'd4, 32'h1100, 32'h2100, 1'b1, 1'b1, 4};
    vecs[2] = '{16'd3, 5'd1, 32'h1200, 32'h2200, 1'b0, 1'b1, 1};
    vecs[3] = '{16'd20, 5'd31, 32'h1300, 32'h2300, 1'b1, 1'b1, 16};
    vecs[4] = '{16'd3, 5'd0, 32'h1400, 32'h2400, 1'b1, 1'b0, 1};
    vecs[5] = '{16'd2, 5'd16, 32'hFFFF_FFFC, 32'h4000, 1'b1, 1'b1, 16};
    tick; tick;
    chk("rst_htrans", bus.htrans, 0);
    chk("rst_haddr", bus.haddr, 0);
    chk("rst_outs", {bus.hwrite, bus.fifo_push, bus.fifo_pop, busy, done_irq, err_irq}, 0);
    rst = 0;
    tick;
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
    // zero-length transfer completes without touching the bus
    rb = rd_a.size();
    cfg(32'h1000, 32'h2000, 16'd0, 5'd4, 1'b1, 1'b1);
    pulse_start;
    chk("zero_done", done_irq, 1);
    chk("zero_busy", busy, 0);
    tick; tick; tick;
    chk("zero_no_bus", rd_a.size() - rb, 0);
    clear_irq("zero");
    // set beats clear in the same cycle
    start = 1; irq_clr = 1; tick; start = 0; irq_clr = 0;
    chk("set_wins", done_irq, 1);
    clear_irq("set_wins");
    // hready low for three cycles on read beat 2
    rb = rd_a.size(); pb = push_n; ob = pop_n;
    cfg(32'h3000, 32'h3800, 16'd4, 5'd4, 1'b1, 1'b1);
    pulse_start;
    t = 0;
    while (!(bus.htrans == 2'b11 && bus.haddr == 32'h3004) && t < 100) begin tick; t++; end
    chk("stall_reach", t < 100, 1);
    bus.hready = 0;
    ns = push_n;
    repeat (3) begin
      tick;
      chk("stall_haddr", bus.haddr, 32'h3004);
      chk("stall_htrans", bus.htrans, 2'b11);
    end
    chk("stall_no_push", push_n, ns);
    bus.hready = 1;
    wait_done("stall");
    chk("stall_pushes", push_n - pb, 4);
    chk("stall_pops", pop_n - ob, 4);
    chk("stall_rd_beats", rd_a.size() - rb, 4);
    clear_irq("stall");
    // pause after write beat 1
    wb = wr_a.size(); ob = pop_n;
    cfg(32'h4800, 32'h5000, 16'd4, 5'd4, 1'b1, 1'b1);
    pulse_start;
    t = 0;
    while (!(bus.htrans == 2'b10 && bus.hwrite && bus.haddr == 32'h5000) && t < 100) begin tick; t++; end
    chk("pause_reach", t < 100, 1);
    channel_en = 0;
    repeat (3) begin
      tick;
      chk("pause_idle", bus.htrans, 2'b00);
    end
    channel_en = 1;
    tick;
    chk("resume_htrans", bus.htrans, 2'b10);
    chk("resume_haddr", bus.haddr, 32'h5004);
    wait_done("pause");
    ns = 0;
    for (int i = wb; i < wr_t.size(); i++) if (wr_t[i] == 2'b10) ns++;
    chk("pause_nonseq", ns, 2);
    chk("pause_pops", pop_n - ob, 4);
    clear_irq("pause");
    // error response on read beat 3
    pb = push_n;
    cfg(32'h6000, 32'h6800, 16'd8, 5'd4, 1'b1, 1'b1);
    pulse_start;
    t = 0;
    while (!(bus.htrans == 2'b11 && !bus.hwrite && bus.haddr == 32'h6008) && t < 100) begin tick; t++; end
    chk("err_reach", t < 100, 1);
    tick;
    bus.hresp = 1;
    tick;
    bus.hresp = 0;
    chk("err_htrans", bus.htrans, 2'b00);
    chk("err_irq", err_irq, 1);
    chk("err_busy", busy, 1);
    cfg(32'h6000, 32'h6800, 16'd4, 5'd4, 1'b1, 1'b1);
    pulse_start;
    tick; tick;
    chk("err_start_ignored", {busy, bus.htrans}, 3'b100);
    chk("err_pushes", push_n - pb, 2);
    clear_irq("err");
    chk("err_to_idle", busy, 0);
    do_reset;
    // reset mid-burst abandons silently
    cfg(32'h7000, 32'h7800, 16'd8, 5'd4, 1'b1, 1'b1);
    pulse_start;
    t = 0;
    while (bus.htrans == 2'b00 && t < 100) begin tick; t++; end
    chk("rst_mid_reach", t < 100, 1);
    tick;
    #2 rst = 1;
    #1;
    chk("rst_mid_htrans", bus.htrans, 0);
    chk("rst_mid_haddr", bus.haddr, 0);
    chk("rst_mid_outs", {bus.hwrite, bus.fifo_push, bus.fifo_pop, busy, done_irq, err_irq}, 0);
    tick; tick;
    rst = 0;
    repeat (5) tick;
    chk("rst_mid_no_irq", {busy, done_irq, err_irq}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
